// File: rtl/ahb_err_responder_pkg.sv
// Shared AHB-Lite encodings plus the state type of the default error responder.
// Imported by every AHB block that needs transfer-type or response decoding.
package ahb_err_responder_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ERR_IDLE = 2'b00,
        ERR_ERR1 = 2'b01,
        ERR_ERR2 = 2'b10
    } err_state_e;

    // NONSEQ and SEQ carry a real transfer; IDLE and BUSY get a zero-wait OKAY.
    function automatic logic htrans_is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_err_responder.sv
// AHB-Lite default slave: answers every selected transfer with a two-cycle ERROR
// and records the first faulting address, a saturating fault count and a sticky irq.
module ahb_err_responder
    import ahb_err_responder_pkg::*;
#(
    parameter logic [31:0] RDATA_PATTERN = 32'hDEAD_BEEF,
    parameter int          CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsel_i,
    input  logic [31:0]      haddr_i,
    input  logic [1:0]       htrans_i,
    input  logic             hwrite_i,
    input  logic             hready_i,
    output logic             hreadyout_o,
    output logic             hresp_o,
    output logic [31:0]      hrdata_o,
    input  logic             clr_i,
    output logic             fault_valid_o,
    output logic [31:0]      fault_addr_o,
    output logic             fault_write_o,
    output logic [CNT_W-1:0] fault_cnt_o,
    output logic             irq_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    err_state_e       state_q;
    logic             hreadyout_q;
    logic             hresp_q;

    logic             valid_q, valid_d;
    logic [31:0]      addr_q, addr_d;
    logic             write_q, write_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q;

    logic             accept;

    // ERR1 drives HREADY low bus-wide, so masking it here only guards against a
    // misbehaving interconnect; a correct bus never presents an accept there.
    assign accept = hsel_i & hready_i & htrans_is_active(htrans_i)
                    & (state_q != ERR_ERR1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ERR_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            case (state_q)
                ERR_IDLE: begin
                    if (accept) begin
                        state_q     <= ERR_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                    end else begin
                        state_q     <= ERR_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                ERR_ERR1: begin
                    state_q     <= ERR_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                ERR_ERR2: begin
                    if (accept) begin
                        state_q     <= ERR_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                    end else begin
                        state_q     <= ERR_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                default: begin
                    state_q     <= ERR_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    // Clear is applied first so a coincident fault becomes the new first fault.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            valid_d = 1'b0;
            cnt_d   = '0;
        end
        if (accept) begin
            if (!valid_d) begin
                addr_d  = haddr_i;
                write_d = hwrite_i;
            end
            valid_d = 1'b1;
            if (clr_i) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
            irq_q   <= valid_d;
        end
    end

    assign hreadyout_o   = hreadyout_q;
    assign hresp_o       = hresp_q;
    assign hrdata_o      = RDATA_PATTERN;
    assign fault_valid_o = valid_q;
    assign fault_addr_o  = addr_q;
    assign fault_write_o = write_q;
    assign fault_cnt_o   = cnt_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_ahb_err_responder.sv
// Bench for ahb_err_responder: a directed vector table followed by random traffic
// checked against a cycle-index model of the error response and fault capture.
module tb_ahb_err_responder;

    localparam int CNT_W = 2;
    localparam logic [31:0] PATTERN = 32'hDEAD_BEEF;

    logic             clk = 1'b0;
    logic             rst;
    logic             hsel_i;
    logic [31:0]      haddr_i;
    logic [1:0]       htrans_i;
    logic             hwrite_i;
    logic             hready_w;
    logic             hreadyout_o;
    logic             hresp_o;
    logic [31:0]      hrdata_o;
    logic             clr_i;
    logic             fault_valid_o;
    logic [31:0]      fault_addr_o;
    logic             fault_write_o;
    logic [CNT_W-1:0] fault_cnt_o;
    logic             irq_o;

    always #5 clk = ~clk;

    // Single-slave bus: the interconnect's HREADY is this slave's HREADYOUT.
    assign hready_w = hreadyout_o;

    ahb_err_responder #(
        .RDATA_PATTERN(PATTERN),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hsel_i       (hsel_i),
        .haddr_i      (haddr_i),
        .htrans_i     (htrans_i),
        .hwrite_i     (hwrite_i),
        .hready_i     (hready_w),
        .hreadyout_o  (hreadyout_o),
        .hresp_o      (hresp_o),
        .hrdata_o     (hrdata_o),
        .clr_i        (clr_i),
        .fault_valid_o(fault_valid_o),
        .fault_addr_o (fault_addr_o),
        .fault_write_o(fault_write_o),
        .fault_cnt_o  (fault_cnt_o),
        .irq_o        (irq_o)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: an error response occupies the two cycles after the edge
    // that accepted it; the bus is stalled only in the first of those cycles.
    int          cyc = 0;
    int          m_last_acc = -100;
    logic        m_valid = 1'b0;
    logic [31:0] m_addr = '0;
    logic        m_write = 1'b0;
    int          m_cnt = 0;
    localparam int M_CNT_MAX = (1 << CNT_W) - 1;

    task automatic model_update();
        logic bus_ready;
        logic acc;
        if (rst) begin
            m_last_acc = -100;
            m_valid = 1'b0;
            m_addr = '0;
            m_write = 1'b0;
            m_cnt = 0;
        end else begin
            bus_ready = (m_last_acc != cyc);
            acc = hsel_i && bus_ready && (htrans_i == 2'b10 || htrans_i == 2'b11);
            if (clr_i) begin
                m_valid = 1'b0;
                m_cnt = 0;
            end
            if (acc) begin
                m_last_acc = cyc + 1;
                if (!m_valid) begin
                    m_addr = haddr_i;
                    m_write = hwrite_i;
                end
                m_valid = 1'b1;
                m_cnt = (m_cnt < M_CNT_MAX) ? m_cnt + 1 : M_CNT_MAX;
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic        rst;
        logic        hsel;
        logic [1:0]  htrans;
        logic [31:0] addr;
        logic        wr;
        logic        clr;
        logic        e_rdy;
        logic        e_resp;
        logic        e_valid;
        logic        e_write;
        logic [31:0] e_addr;
        int          e_cnt;
    } vec_t;

    vec_t vecs[19];

    initial begin
        rst = 1'b1; hsel_i = 1'b0; haddr_i = '0; htrans_i = 2'b00; hwrite_i = 1'b0; clr_i = 1'b0;

        //           rst hsel tr     addr          wr clr  rdy resp val wr  addr          cnt
        vecs[0]  = '{1, 0, 2'b00, 32'h0,         0, 0,   1, 0, 0, 0, 32'h0,         0};
        vecs[1]  = '{0, 1, 2'b10, 32'h9000_0000, 0, 0,   0, 1, 1, 0, 32'h9000_0000, 1};
        vecs[2]  = '{0, 1, 2'b10, 32'hA000_0004, 1, 0,   1, 1, 1, 0, 32'h9000_0000, 1};
        vecs[3]  = '{0, 1, 2'b10, 32'hA000_0004, 1, 0,   0, 1, 1, 0, 32'h9000_0000, 2};
        vecs[4]  = '{0, 1, 2'b11, 32'hA000_0008, 1, 0,   1, 1, 1, 0, 32'h9000_0000, 2};
        vecs[5]  = '{0, 1, 2'b00, 32'hA000_0008, 1, 0,   1, 0, 1, 0, 32'h9000_0000, 2};
        vecs[6]  = '{0, 1, 2'b01, 32'hA000_000C, 0, 0,   1, 0, 1, 0, 32'h9000_0000, 2};
        vecs[7]  = '{0, 1, 2'b00, 32'hA000_0010, 0, 0,   1, 0, 1, 0, 32'h9000_0000, 2};
        vecs[8]  = '{0, 1, 2'b10, 32'h9100_0000, 1, 0,   0, 1, 1, 0, 32'h9000_0000, 3};
        vecs[9]  = '{0, 0, 2'b00, 32'h0,         0, 0,   1, 1, 1, 0, 32'h9000_0000, 3};
        vecs[10] = '{0, 1, 2'b11, 32'h9100_0004, 1, 0,   0, 1, 1, 0, 32'h9000_0000, 3};
        vecs[11] = '{0, 0, 2'b00, 32'h0,         0, 0,   1, 1, 1, 0, 32'h9000_0000, 3};
        vecs[12] = '{0, 1, 2'b10, 32'h9200_0000, 0, 0,   0, 1, 1, 0, 32'h9000_0000, 3};
        vecs[13] = '{0, 0, 2'b00, 32'h0,         0, 0,   1, 1, 1, 0, 32'h9000_0000, 3};
        vecs[14] = '{0, 1, 2'b10, 32'hB000_0000, 1, 1,   0, 1, 1, 1, 32'hB000_0000, 1};
        vecs[15] = '{1, 1, 2'b10, 32'hB000_0004, 0, 0,   1, 0, 0, 0, 32'h0,         0};
        vecs[16] = '{0, 1, 2'b10, 32'hC000_0010, 0, 0,   0, 1, 1, 0, 32'hC000_0010, 1};
        vecs[17] = '{0, 0, 2'b00, 32'h0,         0, 1,   1, 1, 0, 0, 32'hC000_0010, 0};
        vecs[18] = '{0, 0, 2'b00, 32'h0,         0, 0,   1, 0, 0, 0, 32'hC000_0010, 0};

        for (int i = 0; i < 19; i++) begin
            rst      = vecs[i].rst;
            hsel_i   = vecs[i].hsel;
            htrans_i = vecs[i].htrans;
            haddr_i  = vecs[i].addr;
            hwrite_i = vecs[i].wr;
            clr_i    = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d hreadyout", i), {31'b0, hreadyout_o}, {31'b0, vecs[i].e_rdy});
            chk($sformatf("vec%0d hresp", i), {31'b0, hresp_o}, {31'b0, vecs[i].e_resp});
            chk($sformatf("vec%0d fault_valid", i), {31'b0, fault_valid_o}, {31'b0, vecs[i].e_valid});
            chk($sformatf("vec%0d irq", i), {31'b0, irq_o}, {31'b0, vecs[i].e_valid});
            chk($sformatf("vec%0d fault_write", i), {31'b0, fault_write_o}, {31'b0, vecs[i].e_write});
            chk($sformatf("vec%0d fault_addr", i), fault_addr_o, vecs[i].e_addr);
            chk($sformatf("vec%0d fault_cnt", i), 32'(fault_cnt_o), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d hrdata", i), hrdata_o, PATTERN);
            $display("[TB] vec%0d rdy=%0d resp=%0d valid=%0d addr=%08h cnt=%0d",
                     i, hreadyout_o, hresp_o, fault_valid_o, fault_addr_o, fault_cnt_o);
        end

        // Random traffic, starting from a clean reset so the model is in sync.
        rst = 1'b1; hsel_i = 1'b0; htrans_i = 2'b00; clr_i = 1'b0;
        tick();
        for (int n = 0; n < 1500; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            hsel_i   = ($urandom_range(0, 9) < 7);
            htrans_i = 2'($urandom_range(0, 3));
            haddr_i  = $urandom;
            hwrite_i = 1'($urandom_range(0, 1));
            clr_i    = ($urandom_range(0, 19) == 0);
            tick();
            chk($sformatf("rnd%0d hreadyout", n), {31'b0, hreadyout_o},
                {31'b0, (m_last_acc != cyc)});
            chk($sformatf("rnd%0d hresp", n), {31'b0, hresp_o},
                {31'b0, (m_last_acc == cyc) || (m_last_acc == cyc - 1)});
            chk($sformatf("rnd%0d fault_valid", n), {31'b0, fault_valid_o}, {31'b0, m_valid});
            chk($sformatf("rnd%0d irq", n), {31'b0, irq_o}, {31'b0, m_valid});
            chk($sformatf("rnd%0d fault_addr", n), fault_addr_o, m_addr);
            chk($sformatf("rnd%0d fault_write", n), {31'b0, fault_write_o}, {31'b0, m_write});
            chk($sformatf("rnd%0d fault_cnt", n), 32'(fault_cnt_o), 32'(m_cnt));
            chk($sformatf("rnd%0d hrdata", n), hrdata_o, PATTERN);
            $display("[TB] rnd%0d rst=%0d sel=%0d tr=%0d clr=%0d -> rdy=%0d resp=%0d cnt=%0d",
                     n, rst, hsel_i, htrans_i, clr_i, hreadyout_o, hresp_o, fault_cnt_o);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
